mux4_arbiter: RTL and testbench
===============================

# mux4_arbiter

Round-robin arbiter and sequencer for a shared 4:1 `WIDTH`-bit datapath mux. Four requesters compete for one downstream consumer. The block selects one requester, drives the mux select, and steers its data to the output with a valid/ready handshake. It holds the grant for a burst of up to `MAX_BURST` beats, then rotates priority. It sits between the requesting units and the shared consumer and replaces a hand-driven mux select.

## Interface
- `WIDTH`, 8, data width of each input and of `y`
- `MAX_BURST`, 4, maximum beats per grant; legal range 1..255

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `req`  in  4  `req[i]` high: requester i has a beat on `d<i>`
- `d0`, `d1`, `d2`, `d3`  in  `WIDTH` each  requester data
- `y_ready`  in  1  consumer accepts the beat on `y` this cycle
- `y`  out  `WIDTH`  selected data; combinational mux of `d0..d3` by `sel`
- `y_valid`  out  1  beat on `y` is valid
- `ack`  out  4  one-hot; `ack[i]` high means requester i's beat was consumed this cycle
- `sel`  out  2  registered grant index; also the mux select
- `busy`  out  1  high in GRANT state

## Operation
- State machine: IDLE, GRANT.
- IDLE arbitration:
  - If `req` is nonzero, pick the first set bit scanning upward from `(last+1) mod 4`, with wrap.
  - Load `sel` with that index, clear `beat_cnt`, go to GRANT.
  - If `req` is zero, stay in IDLE with `sel` unchanged.
- GRANT outputs:
  - `y_valid = req[sel]`.
  - `ack[sel] = req[sel] & y_ready`; all other `ack` bits are 0.
- GRANT beat counting: on each ack, `beat_cnt` increments. `beat_cnt` is 8 bits and never exceeds `MAX_BURST`.
- GRANT release. Release happens at the clock edge where either:
  - (a) `req[sel]` is low, or
  - (b) an ack occurs with `beat_cnt == MAX_BURST-1`.
  - On release: `last <= sel`, go to IDLE.
- Requester rules:
  - Hold `d<i>` stable while `req[i]` is high and not acked.
  - A requester may drop `req` after any ack to end its burst early.
- Losing requesters see no `ack` and wait. Each requester is guaranteed service within 3 grants of raising `req` (fairness).
- In IDLE, `y_valid`, `ack` and `busy` are all 0, and `y` still shows `d<sel>`.
- Reset (async assert, sync deassert by the system):
  - State IDLE, `sel`=0, `last`=3, `beat_cnt`=0.
  - Outputs: `y_valid`=0, `ack`=0, `busy`=0, `y`=`d0`.
  - Any in-progress burst is abandoned without ack.

## Timing
- Arbitration latency: `req` high in IDLE at edge N gives `busy`/`sel` valid after edge N, so the first possible ack is in cycle N+1.
- Every grant is followed by exactly one IDLE cycle (bubble). A requester that keeps `req` high after an ack of beat `MAX_BURST` re-competes in that IDLE cycle at lowest priority.
- `y`, `y_valid` and `ack` are combinational from registered `sel`/state plus live `req`/`y_ready`/`d`. No registered data stage; zero data latency.
- Back-to-back acks: one beat per cycle while `req[sel]` and `y_ready` are both high.
- Simultaneous events:
  - Ack of the final beat and `req[sel]` dropping in the same cycle: single release, counted once.
  - `y_ready` low: no ack and `beat_cnt` holds. The grant is held indefinitely while `req[sel]` stays high.
- `MAX_BURST`=1: every grant is exactly one beat followed by an IDLE bubble.

## Test plan
- Reset/idle: `rst_n`=0 mid-GRANT with `sel`=2 → immediately `busy`=0, `y_valid`=0, `ack`=0, `sel`=0. After release with `req`=0, the block stays idle and `y`=`d0`.
- Single requester burst: `req`=0001, `y_ready`=1, `d0`=A5, `MAX_BURST`=4 → IDLE, then 4 cycles `ack`=0001 with `y`=A5, then 1 IDLE cycle, then a new grant to 0.
- Round-robin rotation: `req`=1111 held, `y_ready`=1 → grant order 0,1,2,3,0. Each grant is 4 acks followed by 1 IDLE cycle.
- Early release: `req`=0101, requester 0 drops `req` after 2 acks → grant passes to 2 after one IDLE cycle, and `last`=0.
- Backpressure: `req`=0010, `y_ready` toggles 1,0,0,1,1,1 → acks only in the 4 cycles where `y_ready`=1. `beat_cnt` holds across the stalls, and release follows the 4th ack.
- Wrap priority: `last`=3, `req`=1001 → grant 0. Then `last`=0, `req`=1001 → grant 3.

Source files
------------

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter and sequencer for a shared 4:1 mux.
// Four requesters compete for one consumer. A winner is picked in IDLE,
// holds the grant for up to MAX_BURST acked beats (or until it drops req),
// then priority rotates past it. Data path is purely combinational.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req      : req[i] high = requester i has a beat on d<i>
//   d0..d3   : requester data
//   y_ready  : consumer accepts the beat on y this cycle
//   y        : d<sel>
//   y_valid  : beat on y is valid (GRANT and req[sel])
//   ack      : one-hot, beat of requester i consumed this cycle
//   sel      : registered grant index / mux select
//   busy     : high in GRANT
//
// state | meaning
// IDLE  | no grant; arbitrate among live requests, one-cycle bubble
// GRANT | requester sel owns the mux; count acked beats until release
module mux4_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [1:0] sel_nxt;
  logic [7:0] beat_cnt, beat_cnt_nxt;
  logic [1:0] pick;
  logic       pick_ok;
  logic       hit;

  // Round-robin pick: scan upward starting just after the last winner.
  always_comb begin
    pick    = 2'd0;
    pick_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = last + 2'(k + 1);
      if (!pick_ok && req[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

  assign busy    = (state == GRANT);
  assign y_valid = busy & req[sel];
  assign hit     = y_valid & y_ready;

  always_comb begin
    ack      = 4'b0000;
    ack[sel] = hit;
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          sel_nxt      = pick;
          beat_cnt_nxt = 8'd0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (hit) beat_cnt_nxt = beat_cnt + 8'd1;
        // Final-beat ack and req drop in the same cycle fold into one release.
        if (!req[sel] || (hit && (beat_cnt == 8'(MAX_BURST - 1)))) begin
          last_nxt  = sel;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      last     <= 2'd3;
      beat_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Testbench for mux4_arbiter: per-cycle vector tables with a scoreboard
// queue, plus hand-written reset sequences. A second instance with
// MAX_BURST=1 shares the inputs and is checked during the rotation run.
module tb_mux4_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'b0;
  logic         y_ready = 1'b0;
  logic [W-1:0] d0 = 8'hA5, d1 = 8'h3C, d2 = 8'h5A, d3 = 8'hC3;

  logic [W-1:0] y, y1;
  logic         y_valid, y_valid1, busy, busy1;
  logic [3:0]   ack, ack1;
  logic [1:0]   sel, sel1;

  mux4_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .y_ready(y_ready), .y(y), .y_valid(y_valid), .ack(ack), .sel(sel), .busy(busy)
  );

  mux4_arbiter #(.WIDTH(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .y_ready(y_ready), .y(y1), .y_valid(y_valid1), .ack(ack1), .sel(sel1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] ack;
    logic       valid;
    logic       chk1;
    logic [1:0] sel1;
    logic       busy1;
    logic [3:0] ack1;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  string tname;

  function automatic logic [W-1:0] dval(input logic [1:0] s);
    case (s)
      2'd0:    return 8'hA5;
      2'd1:    return 8'h3C;
      2'd2:    return 8'h5A;
      default: return 8'hC3;
    endcase
  endfunction

  task automatic chk(input string what, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] %s: got %0h want %0h", tname, idx, what, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic rd, input logic [1:0] s,
                     input logic b, input logic [3:0] a, input logic v);
    vec_t t;
    t.req = r; t.rdy = rd; t.sel = s; t.busy = b; t.ack = a; t.valid = v;
    t.chk1 = 1'b0; t.sel1 = 2'd0; t.busy1 = 1'b0; t.ack1 = 4'b0;
    vecs.push_back(t);
  endtask

  // Idle cycle shortcut and grant cycle with ack.
  task automatic add_idle(input logic [3:0] r, input logic [1:0] s);
    add(r, 1'b1, s, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic add_ack(input logic [3:0] r, input logic [1:0] s);
    add(r, 1'b1, s, 1'b1, 4'b0001 << s, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0;
    y_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vecs();
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req     = vecs[i].req;
      y_ready = vecs[i].rdy;
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      chk("sel",     i, 32'(sel),     32'(e.sel));
      chk("busy",    i, 32'(busy),    32'(e.busy));
      chk("ack",     i, 32'(ack),     32'(e.ack));
      chk("y_valid", i, 32'(y_valid), 32'(e.valid));
      chk("y",       i, 32'(y),       32'(dval(e.sel)));
      if (e.chk1) begin
        chk("sel_mb1",  i, 32'(sel1),  32'(e.sel1));
        chk("busy_mb1", i, 32'(busy1), 32'(e.busy1));
        chk("ack_mb1",  i, 32'(ack1),  32'(e.ack1));
        chk("y_mb1",    i, 32'(y1),    32'(dval(e.sel1)));
      end
    end
    vecs.delete();
  endtask

  initial begin
    // Single requester burst, rebid after bubble, then drop to idle.
    tname = "single";
    do_reset();
    add_idle(4'b0001, 2'd0);
    for (int i = 0; i < 4; i++) add_ack(4'b0001, 2'd0);
    add_idle(4'b0001, 2'd0);
    add_ack(4'b0001, 2'd0);
    add(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0);
    add_idle(4'b0000, 2'd0);
    add_idle(4'b0000, 2'd0);
    run_vecs();

    // Full rotation 0,1,2,3,0; MAX_BURST=1 instance alternates grant/bubble.
    tname = "rotate";
    do_reset();
    for (int g = 0; g < 4; g++) begin
      add_idle(4'b1111, (g == 0) ? 2'd0 : 2'(g - 1));
      for (int b = 0; b < 4; b++) add_ack(4'b1111, 2'(g));
    end
    add_idle(4'b1111, 2'd3);
    add_ack(4'b1111, 2'd0);
    for (int c = 0; c < vecs.size(); c++) begin
      vecs[c].chk1 = 1'b1;
      if (c % 2 == 0) begin
        vecs[c].sel1  = (c == 0) ? 2'd0 : 2'((c / 2 - 1) % 4);
        vecs[c].busy1 = 1'b0;
        vecs[c].ack1  = 4'b0000;
      end else begin
        vecs[c].sel1  = 2'(((c - 1) / 2) % 4);
        vecs[c].busy1 = 1'b1;
        vecs[c].ack1  = 4'b0001 << vecs[c].sel1;
      end
    end
    run_vecs();

    // Early release by requester 0; re-raising it must still lose to 2.
    tname = "early";
    do_reset();
    add_idle(4'b0101, 2'd0);
    add_ack(4'b0101, 2'd0);
    add_ack(4'b0101, 2'd0);
    add(4'b0100, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0);
    add_idle(4'b0101, 2'd0);
    for (int i = 0; i < 4; i++) add_ack(4'b0101, 2'd2);
    add_idle(4'b0101, 2'd2);
    add_ack(4'b0101, 2'd0);
    run_vecs();

    // Backpressure: y_ready 1,0,0,1,1,1 gives four acks then release.
    tname = "bpress";
    do_reset();
    add_idle(4'b0010, 2'd0);
    add(4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1);
    add(4'b0010, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b1);
    add(4'b0010, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b1);
    add(4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1);
    add(4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1);
    add(4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1);
    add_idle(4'b0000, 2'd1);
    add_idle(4'b0000, 2'd1);
    run_vecs();

    // Wrap priority: last=3 -> 0 wins, then last=0 -> 3 wins.
    tname = "wrap";
    do_reset();
    add_idle(4'b1001, 2'd0);
    for (int i = 0; i < 4; i++) add_ack(4'b1001, 2'd0);
    add_idle(4'b1001, 2'd0);
    add_ack(4'b1001, 2'd3);
    run_vecs();

    // Asynchronous reset mid-GRANT with sel=2.
    tname = "areset";
    do_reset();
    add_idle(4'b0100, 2'd0);
    add(4'b0100, 1'b0, 2'd2, 1'b1, 4'b0000, 1'b1);
    run_vecs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("busy",    0, 32'(busy),    32'd0);
    chk("y_valid", 0, 32'(y_valid), 32'd0);
    chk("ack",     0, 32'(ack),     32'd0);
    chk("sel",     0, 32'(sel),     32'd0);
    chk("y",       0, 32'(y),       32'(8'hA5));
    chk("busy_mb1", 0, 32'(busy1),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000;
    y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_busy", i, 32'(busy), 32'd0);
      chk("idle_sel",  i, 32'(sel),  32'd0);
      chk("idle_y",    i, 32'(y),    32'(8'hA5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
